// File: rtl/pipe_div_pkg.sv
// Shared widths and per-stage bundle for the pipelined restoring divider.
// The bundle here is sized for the default build; other widths pass their own type.
package pipe_div_pkg;

  localparam int DEF_Z_W   = 28;
  localparam int DEF_D_W   = 20;
  localparam int DEF_Q_W   = 8;
  localparam int DEF_TAG_W = 4;

  // Width needed to compare the dividend against a divisor shifted by up to q_w bits.
  function automatic int cmp_width(input int z_w, input int d_w, input int q_w);
    return ((z_w > d_w) ? z_w : d_w) + q_w;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 dbz;
    logic                 ovf;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_Q_W-1:0]   q;
    logic [DEF_D_W-1:0]   d;
    logic [DEF_Z_W-1:0]   p;
  } stage_t;

endpackage

// File: rtl/pipe_divider_p_if.sv
// Request/result bundle between the accumulator datapath and the divider.
interface pipe_divider_p_if
  import pipe_div_pkg::*;
#(
  parameter int Z_W   = DEF_Z_W,
  parameter int D_W   = DEF_D_W,
  parameter int Q_W   = DEF_Q_W,
  parameter int TAG_W = DEF_TAG_W
);
  // start is a one-cycle valid with no ready: an op is taken on every edge with
  // start=1 and stall=0. stall freezes the whole pipeline, outputs included, and
  // StartOut marks a result that is consumed on the next unstalled edge.
  logic             stall;
  logic             start;
  logic [Z_W-1:0]   divided;
  logic [D_W-1:0]   divisor;
  logic [TAG_W-1:0] tag_in;
  logic [Q_W-1:0]   q;
  logic [D_W-1:0]   r;
  logic [TAG_W-1:0] tag_out;
  logic             StartOut;
  logic             div_by_0;
  logic             overflow;

  modport master (
    output stall, start, divided, divisor, tag_in,
    input  q, r, tag_out, StartOut, div_by_0, overflow
  );

  modport slave (
    input  stall, start, divided, divisor, tag_in,
    output q, r, tag_out, StartOut, div_by_0, overflow
  );
endinterface

// File: rtl/pipe_div_stage.sv
// One restoring-division step for quotient bit BIT, registered with hold on stall.
module pipe_div_stage
  import pipe_div_pkg::*;
#(
  parameter int  Z_W = DEF_Z_W,
  parameter int  D_W = DEF_D_W,
  parameter int  Q_W = DEF_Q_W,
  parameter int  BIT = 0,
  parameter type bundle_t = stage_t
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    stall,
  input  bundle_t stage_i,
  output bundle_t stage_o
);

  localparam int CW = cmp_width(Z_W, D_W, Q_W);

  bundle_t       stage_d;
  bundle_t       stage_q;
  logic [CW-1:0] p_ext;
  logic [CW-1:0] d_shift;

  always_comb begin
    p_ext   = CW'(stage_i.p);
    d_shift = CW'(stage_i.d) << BIT;
    stage_d = stage_i;
    if (p_ext >= d_shift) begin
      stage_d.p      = Z_W'(p_ext - d_shift);
      stage_d.q[BIT] = 1'b1;
    end else begin
      stage_d.q[BIT] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else if (!stall) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/pipe_divider_p.sv
// Pipelined unsigned restoring divider: one op per unstalled cycle, result
// Q_W cycles later with tag, divide-by-zero and overflow flags.
module pipe_divider_p
  import pipe_div_pkg::*;
#(
  parameter int Z_W   = DEF_Z_W,
  parameter int D_W   = DEF_D_W,
  parameter int Q_W   = DEF_Q_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input logic             clock,
  input logic             reset,
  pipe_divider_p_if.slave bus
);

  localparam int CW = cmp_width(Z_W, D_W, Q_W);

  typedef struct packed {
    logic             valid;
    logic             dbz;
    logic             ovf;
    logic [TAG_W-1:0] tag;
    logic [Q_W-1:0]   q;
    logic [D_W-1:0]   d;
    logic [Z_W-1:0]   p;
  } bundle_t;

  // chain[Q_W] is the unregistered entry bundle; chain[i] leaves the stage for bit i.
  bundle_t       chain [0:Q_W];
  bundle_t       head;
  logic [CW-1:0] z_ext;
  logic [CW-1:0] d_top;

  // Flags are decided on entry so they travel with the op instead of being recomputed.
  always_comb begin
    z_ext      = CW'(bus.divided);
    d_top      = CW'(bus.divisor) << Q_W;
    head       = '0;
    head.valid = bus.start;
    head.dbz   = (bus.divisor == '0);
    head.ovf   = (bus.divisor != '0) && (z_ext >= d_top);
    head.tag   = bus.tag_in;
    head.d     = bus.divisor;
    head.p     = bus.divided;
  end

  assign chain[Q_W] = head;

  for (genvar i = Q_W - 1; i >= 0; i--) begin : g_stage
    pipe_div_stage #(
      .Z_W      (Z_W),
      .D_W      (D_W),
      .Q_W      (Q_W),
      .BIT      (i),
      .bundle_t (bundle_t)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .stall   (bus.stall),
      .stage_i (chain[i+1]),
      .stage_o (chain[i])
    );
  end

  bundle_t          last;
  logic [CW-1:0]    p_last;
  logic [Q_W-1:0]   q_d,   q_q;
  logic [D_W-1:0]   r_d,   r_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             valid_d, valid_q;
  logic             dbz_d, dbz_q;
  logic             ovf_d, ovf_q;

  assign last   = chain[0];
  assign p_last = CW'(last.p);

  // With d=0 every trial subtracts nothing, so p still holds the dividend here.
  always_comb begin
    q_d     = '0;
    r_d     = '0;
    tag_d   = '0;
    valid_d = 1'b0;
    dbz_d   = 1'b0;
    ovf_d   = 1'b0;
    if (last.valid) begin
      valid_d = 1'b1;
      tag_d   = last.tag;
      if (last.dbz) begin
        dbz_d = 1'b1;
        q_d   = '1;
        r_d   = p_last[D_W-1:0];
      end else if (last.ovf) begin
        ovf_d = 1'b1;
        q_d   = '1;
      end else begin
        q_d = last.q;
        r_d = p_last[D_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q     <= '0;
      r_q     <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!bus.stall) begin
      q_q     <= q_d;
      r_q     <= r_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.tag_out  = tag_q;
  assign bus.StartOut = valid_q;
  assign bus.div_by_0 = dbz_q;
  assign bus.overflow = ovf_q;

  logic unused_last_bits;
  assign unused_last_bits = ^{last.d, p_last[CW-1:D_W]};

endmodule

// File: tb/tb_pipe_divider_p.sv
// Bench for pipe_divider_p: directed vectors with literal results plus a
// division model that tracks every accepted op through stalls and resets.
module tb_pipe_divider_p;
  import pipe_div_pkg::*;

  localparam int Z_W   = DEF_Z_W;
  localparam int D_W   = DEF_D_W;
  localparam int Q_W   = DEF_Q_W;
  localparam int TAG_W = DEF_TAG_W;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipe_divider_p_if #(.Z_W(Z_W), .D_W(D_W), .Q_W(Q_W), .TAG_W(TAG_W)) bus ();

  pipe_divider_p #(.Z_W(Z_W), .D_W(D_W), .Q_W(Q_W), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [Q_W-1:0]   q;
    logic [D_W-1:0]   r;
    logic [TAG_W-1:0] tag;
    logic             dbz;
    logic             ovf;
    int               due;
    logic             has_lit;
    logic [Q_W-1:0]   lq;
    logic [D_W-1:0]   lr;
    logic             ldbz;
    logic             lovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   adv_cnt   = 0;
  int   edge_kind = 0;  // 0 reset edge, 1 stalled edge, 2 advancing edge

  logic             lit_has  = 1'b0;
  logic [Q_W-1:0]   lit_q    = '0;
  logic [D_W-1:0]   lit_r    = '0;
  logic             lit_dbz  = 1'b0;
  logic             lit_ovf  = 1'b0;

  logic [Q_W+D_W+TAG_W+2:0] prev_out = '0;
  logic [Q_W+D_W+TAG_W+2:0] cur_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t golden(input logic [Z_W-1:0] z, input logic [D_W-1:0] d,
                                  input logic [TAG_W-1:0] t);
    exp_t   e;
    longint zz;
    longint dd;
    zz    = longint'(z);
    dd    = longint'(d);
    e     = '{default: '0};
    e.tag = t;
    if (dd == 0) begin
      e.dbz = 1'b1;
      e.q   = '1;
      e.r   = z[D_W-1:0];
    end else if (zz / dd > (longint'(1) << Q_W) - 1) begin
      e.ovf = 1'b1;
      e.q   = '1;
      e.r   = '0;
    end else begin
      e.q = Q_W'(zz / dd);
      e.r = D_W'(zz % dd);
    end
    return e;
  endfunction

  // Model: an op accepted on advancing edge n must appear after advancing edge n+Q_W.
  always @(posedge clock) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      edge_kind = 0;
    end else if (bus.stall) begin
      edge_kind = 1;
    end else begin
      adv_cnt++;
      edge_kind = 2;
      if (bus.start) begin
        e         = golden(bus.divided, bus.divisor, bus.tag_in);
        e.due     = adv_cnt + Q_W;
        e.has_lit = lit_has;
        e.lq      = lit_q;
        e.lr      = lit_r;
        e.ldbz    = lit_dbz;
        e.lovf    = lit_ovf;
        exp_q.push_back(e);
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    cur_out = {bus.StartOut, bus.div_by_0, bus.overflow, bus.tag_out, bus.q, bus.r};
    if (reset || edge_kind == 0) begin
      chk("reset_zero", 64'(cur_out), 64'(0));
    end else if (edge_kind == 1) begin
      chk("stall_hold", 64'(cur_out), 64'(prev_out));
    end else if (exp_q.size() > 0 && exp_q[0].due == adv_cnt) begin
      e = exp_q.pop_front();
      chk("valid", 64'(bus.StartOut), 64'(1));
      chk("q", 64'(bus.q), 64'(e.q));
      chk("r", 64'(bus.r), 64'(e.r));
      chk("tag", 64'(bus.tag_out), 64'(e.tag));
      chk("div_by_0", 64'(bus.div_by_0), 64'(e.dbz));
      chk("overflow", 64'(bus.overflow), 64'(e.ovf));
      if (e.has_lit) begin
        chk("lit_q", 64'(bus.q), 64'(e.lq));
        chk("lit_r", 64'(bus.r), 64'(e.lr));
        chk("lit_flags", 64'({bus.div_by_0, bus.overflow}), 64'({e.ldbz, e.lovf}));
      end
    end else begin
      chk("idle_zero", 64'(cur_out), 64'(0));
    end
    prev_out = cur_out;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic [Z_W-1:0] z, input logic [D_W-1:0] d,
                          input logic [TAG_W-1:0] t, input logic has,
                          input logic [Q_W-1:0] lq, input logic [D_W-1:0] lr,
                          input logic ldbz, input logic lovf);
    bus.start   = 1'b1;
    bus.divided = z;
    bus.divisor = d;
    bus.tag_in  = t;
    lit_has     = has;
    lit_q       = lq;
    lit_r       = lr;
    lit_dbz     = ldbz;
    lit_ovf     = lovf;
    step();
    bus.start = 1'b0;
    lit_has   = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) step();
  endtask

  // start is left high with junk operands to show stalled cycles accept nothing.
  task automatic stall_n(input int n);
    bus.stall = 1'b1;
    repeat (n) begin
      bus.start   = 1'($urandom_range(0, 1));
      bus.divided = Z_W'($urandom());
      bus.divisor = D_W'($urandom());
      bus.tag_in  = TAG_W'($urandom());
      step();
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic random_op();
    int               m;
    longint           dl;
    longint           zl;
    logic [Z_W-1:0]   z;
    logic [D_W-1:0]   d;
    m  = $urandom_range(0, 7);
    dl = longint'($urandom_range(1, (1 << D_W) - 1));
    case (m)
      0: begin dl = 0; zl = longint'(Z_W'($urandom())); end
      1: begin dl = longint'($urandom_range(1, 255)); zl = longint'(Z_W'($urandom())); end
      2: zl = dl * 256;
      3: zl = dl * 256 - 1;
      default: zl = dl * longint'($urandom_range(0, 255)) + longint'($urandom_range(0, int'(dl) - 1));
    endcase
    z = Z_W'(zl);
    d = D_W'(dl);
    drive_op(z, d, TAG_W'($urandom()), 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ops;
    int sel;
    bus.stall   = 1'b0;
    bus.start   = 1'b0;
    bus.divided = '0;
    bus.divisor = '0;
    bus.tag_in  = '0;
    reset       = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    idle(2);

    // Back-to-back ops, results on consecutive cycles.
    drive_op(28'd765,  20'd63, 4'd0, 1'b1, 8'd12,  20'd9,  1'b0, 1'b0);
    drive_op(28'd3315, 20'd63, 4'd0, 1'b1, 8'd52,  20'd39, 1'b0, 1'b0);
    drive_op(28'd5865, 20'd63, 4'd0, 1'b1, 8'd93,  20'd6,  1'b0, 1'b0);
    drive_op(28'd9180, 20'd63, 4'd0, 1'b1, 8'd145, 20'd45, 1'b0, 1'b0);
    idle(12);

    // Overflow boundary, divide by zero, full-width boundaries.
    drive_op(28'd16128, 20'd63, 4'd0, 1'b1, 8'hFF, 20'd0,  1'b0, 1'b1);
    drive_op(28'd16127, 20'd63, 4'd0, 1'b1, 8'd255, 20'd62, 1'b0, 1'b0);
    drive_op(28'd1000,  20'd0,  4'd0, 1'b1, 8'hFF, 20'd1000, 1'b1, 1'b0);
    drive_op(28'hFFFFFFF, 20'hFFFFF, 4'd9, 1'b1, 8'hFF, 20'd0, 1'b0, 1'b1);
    drive_op(28'd268435199, 20'hFFFFF, 4'd10, 1'b1, 8'd255, 20'd1048574, 1'b0, 1'b0);
    drive_op(28'd0, 20'd5, 4'd11, 1'b1, 8'd0, 20'd0, 1'b0, 1'b0);
    idle(12);

    // Tagged ops with a 3-cycle stall mid-flight.
    drive_op(28'd100, 20'd7, 4'd1, 1'b1, 8'd14,  20'd2, 1'b0, 1'b0);
    drive_op(28'd200, 20'd9, 4'd2, 1'b1, 8'd22,  20'd2, 1'b0, 1'b0);
    drive_op(28'd255, 20'd1, 4'd3, 1'b1, 8'd255, 20'd0, 1'b0, 1'b0);
    idle(2);
    stall_n(3);
    idle(12);

    // Reset mid-flight: the op must never complete.
    drive_op(28'd500, 20'd7, 4'd5, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(2);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    idle(15);
    drive_op(28'd1000, 20'd10, 4'd6, 1'b1, 8'd100, 20'd0, 1'b0, 1'b0);
    idle(12);

    // Random ops with stalls and bubbles.
    ops = 0;
    while (ops < 10000) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
        stall_n($urandom_range(1, 3));
      end else if (sel == 1) begin
        idle(1);
      end else begin
        random_op();
        ops++;
      end
    end

    bus.start = 1'b0;
    bus.stall = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
